// File: rtl/gray_decode_arbiter.sv
// Round-robin (or fixed-priority with GRAY_DECODE_ARBITER_FIXED_PRIO_EN) arbiter sharing one
// Gray-to-binary decoder among REQ_NUM requesters; 1-cycle latency, one-entry output stage.
module gray_decode_arbiter #(
    parameter  int DATA_WIDTH = 4,
    parameter  int REQ_NUM    = 4,
    localparam int ID_WIDTH   = $clog2(REQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_gray_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [DATA_WIDTH-1:0]         res_bin_o,
    output logic [ID_WIDTH-1:0]           res_id_o
);

    logic                  res_valid_q;
    logic [DATA_WIDTH-1:0] res_bin_q, res_bin_d;
    logic [ID_WIDTH-1:0]   res_id_q;
    logic                  grant_vld;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [DATA_WIDTH-1:0] gray_sel;
    logic                  can_accept;
    logic                  xfer;

`ifdef GRAY_DECODE_ARBITER_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        // Descending scan so the lowest index is the last (winning) assignment.
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                grant_vld = 1'b1;
                grant_id  = ID_WIDTH'(i);
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        // Descending offset scan: the smallest offset from the pointer wins.
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            if (req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (int'(grant_id) == REQ_NUM - 1) ? '0 : grant_id + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign can_accept  = !res_valid_q || res_ready_i;
    assign req_ready_o = (!rst_i && can_accept && grant_vld) ? (REQ_NUM'(1) << grant_id) : '0;
    assign xfer        = |(req_ready_o & req_valid_i);

    assign gray_sel = req_gray_i[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        res_bin_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            res_bin_d[i] = ^(gray_sel >> i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_bin_q   <= '0;
            res_id_q    <= '0;
        end else if (xfer) begin
            res_valid_q <= 1'b1;
            res_bin_q   <= res_bin_d;
            res_id_q    <= grant_id;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_bin_o   = res_bin_q;
    assign res_id_o    = res_id_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected {id,bin}; negedge monitors pop on accept.
module tb_gray_decode_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 requesters
    logic        rst_a;
    logic [3:0]  vld_a;
    logic [15:0] gray_a;
    logic [3:0]  rdy_a;
    logic        rv_a, rr_a;
    logic [3:0]  bin_a;
    logic [1:0]  id_a;

    // Instance B: 3 requesters (non-power-of-2 wrap)
    logic        rst_b;
    logic [2:0]  vld_b;
    logic [11:0] gray_b;
    logic [2:0]  rdy_b;
    logic        rv_b, rr_b;
    logic [3:0]  bin_b;
    logic [1:0]  id_b;

    gray_decode_arbiter #(.DATA_WIDTH(4), .REQ_NUM(4)) u_a (
        .clk_i(clk), .rst_i(rst_a), .req_valid_i(vld_a), .req_gray_i(gray_a),
        .req_ready_o(rdy_a), .res_valid_o(rv_a), .res_ready_i(rr_a),
        .res_bin_o(bin_a), .res_id_o(id_a));

    gray_decode_arbiter #(.DATA_WIDTH(4), .REQ_NUM(3)) u_b (
        .clk_i(clk), .rst_i(rst_b), .req_valid_i(vld_b), .req_gray_i(gray_b),
        .req_ready_o(rdy_b), .res_valid_o(rv_b), .res_ready_i(rr_b),
        .res_bin_o(bin_b), .res_id_o(id_b));

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] qa[$];
    logic [5:0] qb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode written as a prefix XOR of shifted copies.
    function automatic logic [3:0] ref_dec(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [5:0] ent(input int id, input logic [3:0] b);
        logic [1:0] i2;
        i2 = 2'(id);
        return {i2, b};
    endfunction

    always @(negedge clk) begin
        if (!rst_a && rv_a && rr_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", {26'd0, id_a, bin_a}, 32'hFFFF_FFFF);
            end else begin
                logic [5:0] e;
                e = qa.pop_front();
                chk("a_res_id", 32'(id_a), 32'(e[5:4]));
                chk("a_res_bin", 32'(bin_a), 32'(e[3:0]));
            end
        end
        if (!rst_b && rv_b && rr_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", {26'd0, id_b, bin_b}, 32'hFFFF_FFFF);
            end else begin
                logic [5:0] e;
                e = qb.pop_front();
                chk("b_res_id", 32'(id_b), 32'(e[5:4]));
                chk("b_res_bin", 32'(bin_b), 32'(e[3:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ids_all[5];
        rst_a = 1'b1; vld_a = 4'hF; gray_a = '0; rr_a = 1'b1;
        rst_b = 1'b1; vld_b = '0;   gray_b = '0; rr_b = 1'b1;
        step();
        step();
        #1;
        chk("reset_ready_zero", 32'(rdy_a), 32'h0);
        chk("reset_res_valid", 32'(rv_a), 32'h0);
        chk("reset_res_bin", 32'(bin_a), 32'h0);
        chk("reset_res_id", 32'(id_a), 32'h0);

        // All four requesting back-to-back
        rst_a = 1'b0; rst_b = 1'b0;
        gray_a = {4'b1000, 4'b1111, 4'b0110, 4'b0011};
        #1;
        chk("all_req_first_ready", 32'(rdy_a), 32'h1);
`ifdef GRAY_DECODE_ARBITER_FIXED_PRIO_EN
        ids_all = '{0, 0, 0, 0, 0};
`else
        ids_all = '{0, 1, 2, 3, 0};
`endif
        foreach (ids_all[k]) begin
            case (ids_all[k])
                0: qa.push_back(ent(0, 4'b0010));
                1: qa.push_back(ent(1, 4'b0100));
                2: qa.push_back(ent(2, 4'b1010));
                default: qa.push_back(ent(3, 4'b1111));
            endcase
        end
        repeat (6) step();

        // Reset while a result is held (pointer at 2 in round-robin build)
        rst_a = 1'b1;
        #1;
        chk("rst_mid_ready_zero", 32'(rdy_a), 32'h0);
        step();
        rst_a = 1'b0;
        #1;
        chk("rst_mid_valid_dropped", 32'(rv_a), 32'h0);
        chk("rst_mid_first_grant", 32'(rdy_a), 32'h1);
        qa.push_back(ent(0, 4'b0010));
        step();
        vld_a = 4'h0;

        // Single request, latency 1
        vld_a = 4'b0001; gray_a = 16'h000D;
        #1;
        chk("single_ready", 32'(rdy_a), 32'h1);
        qa.push_back(ent(0, 4'b1001));
        step();
        vld_a = 4'b0000;
        #1;
        chk("single_valid_next", 32'(rv_a), 32'h1);
        step();
        chk("single_valid_drop", 32'(rv_a), 32'h0);

        // Backpressure with requester 2 waiting
        rr_a = 1'b0; vld_a = 4'b0100; gray_a = 16'h0500;
        qa.push_back(ent(2, 4'b0110));
        step();
        gray_a = 16'h0A00;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready_zero", 32'(rdy_a), 32'h0);
            chk("bp_bin_hold", 32'(bin_a), 32'h6);
            chk("bp_id_hold", 32'(id_a), 32'h2);
            step();
        end
        rr_a = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rdy_a), 32'h4);
        qa.push_back(ent(2, 4'b1100));
        step();
        vld_a = 4'b0000;
        step();

        // Exhaustive decode sweep through requester 3
        for (int g = 0; g < 16; g++) begin
            vld_a = 4'b1000;
            gray_a = {4'(g), 12'h000};
            qa.push_back(ent(3, ref_dec(4'(g))));
            step();
        end
        vld_a = 4'b0000;

        // Wrap on 3 requesters with 0 and 2 valid
        vld_b = 3'b101;
        gray_b = {4'b0010, 4'b0000, 4'b0001};
`ifdef GRAY_DECODE_ARBITER_FIXED_PRIO_EN
        repeat (4) qb.push_back(ent(0, 4'b0001));
`else
        qb.push_back(ent(0, 4'b0001));
        qb.push_back(ent(2, 4'b0011));
        qb.push_back(ent(0, 4'b0001));
        qb.push_back(ent(2, 4'b0011));
`endif
        repeat (4) step();
        vld_b = 3'b000;

        for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) step();
        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
        repeat (2) step();
        chk("a_idle_valid", 32'(rv_a), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray_decode_arbiter.md
Name: gray_decode_arbiter

Overview:
- Shares one Gray-to-binary conversion datapath between REQ_NUM requesters.
- Each requester presents a Gray code with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle; its code is converted and registered into a single-entry output stage, tagged with the requester index.
- Sits between Gray-coded pointer/counter sources (e.g. several FIFO pointer domains already synchronized into this clock) and binary consumers.

Parameters:
- DATA_WIDTH, 4, width of each Gray code and of the binary result.
- REQ_NUM, 4, number of requesters; legal range 2..16.
- ID_WIDTH, $clog2(REQ_NUM), width of the requester index; derived, not overridden.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  REQ_NUM  per-requester valid; bit k belongs to requester k.
- req_gray_i  input  REQ_NUM*DATA_WIDTH  packed Gray codes; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  REQ_NUM  per-requester ready; at most one bit high (one-hot or zero).
- res_valid_o  output  1  output stage holds a result.
- res_ready_i  input  1  consumer accepts the result.
- res_bin_o  output  DATA_WIDTH  binary value of the granted Gray code.
- res_id_o  output  ID_WIDTH  index of the requester that produced res_bin_o.

Behaviour:
- Reset: sampled on the clock edge.
  - res_valid_o=0, res_bin_o=0, res_id_o=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready_o is combinationally 0 while rst_i=1.
- Conversion: bin[DATA_WIDTH-1]=gray[DATA_WIDTH-1]; bin[i]=gray[i]^bin[i+1], computed combinationally on the granted requester's code only.
- Output stage (states EMPTY/FULL, tracked by res_valid_o):
  - can_accept = !res_valid_o || res_ready_i.
  - Grant: the first requester with req_valid_i=1 searching circularly from the pointer (pointer, pointer+1, ..., wrapping modulo REQ_NUM).
  - req_ready_o[g]=1 only when can_accept=1 and a grant exists; else all zero.
  - Transfer on requester g: req_valid_i[g] && req_ready_o[g]. Next cycle: res_valid_o=1, res_bin_o=converted code, res_id_o=g. Latency 1 cycle.
  - Output consumed without new transfer (res_valid_o && res_ready_i): res_valid_o=0 next cycle; res_bin_o/res_id_o hold their last value.
  - Simultaneous consume and new transfer: the output stage reloads in the same cycle, giving 1 result/cycle sustained throughput with no bubble.
  - FULL and res_ready_i=0: all req_ready_o=0; res_bin_o and res_id_o stable until accepted.
- Pointer: after each transfer with grant g, pointer = (g+1) mod REQ_NUM, with explicit wrap for non-power-of-2 REQ_NUM. The pointer is unchanged when no transfer occurs.
- Requester rules:
  - Requester k holds req_gray_i slice stable while req_valid_i[k]=1 and not yet accepted.
  - The arbiter does not latch the code before the transfer.
  - Deasserting valid before acceptance is allowed; the grant is re-evaluated every cycle.
- No valid requests: req_ready_o=0; pointer holds.
- Reset mid-operation: any held result is dropped (res_valid_o=0); the pointer returns to 0; no transfer is reported in the reset cycle.
- req_ready_o depends combinationally on req_valid_i, res_valid_o, res_ready_i and the pointer. There are no registered ready paths.

Optional Feature:
- Macro: GRAY_DECODE_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins; the pointer register is not instantiated.
- Undefined (default): round-robin as described above.
- Handshake, latency and reset values are identical in both builds.

Test Plan:
- Single request, DATA_WIDTH=4: req_valid_i=4'b0001, gray=4'b1101, res_ready_i=1 -> next cycle res_valid_o=1, res_bin_o=4'b1001, res_id_o=0; following cycle res_valid_o=0.
- All four requesting continuously, res_ready_i=1 -> res_id_o sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles. With GRAY_DECODE_ARBITER_FIXED_PRIO_EN defined -> res_id_o constant 0.
- Backpressure: result held, res_ready_i=0 for 3 cycles with req 2 valid -> req_ready_o=0 and res_bin_o/res_id_o unchanged for those 3 cycles. Raise res_ready_i -> req 2 granted same cycle, its result appears next cycle.
- Pointer wrap with REQ_NUM=3 and requesters 0 and 2 valid, starting pointer 0 -> grants 0,2,0,2.
- Exhaustive conversion: for one requester, sweep gray 0..15 -> res_bin_o matches reference decode for all 16 values.
- Reset mid-operation: rst_i=1 for one cycle while res_valid_o=1 and pointer=2 -> res_valid_o=0, and after release with all requesting, first grant is requester 0.
